gac_win_sched: RTL and testbench
================================

// Module: gac_win_sched
// PURPOSE
//  Measurement-window scheduler feeding the SCM start/end inputs (gac2scm_sent_start/end).
//  Software programs window length, gap length and window count over the 134-bit config chain.
//  The block then sequences N statistic windows autonomously and exposes progress for readback.
//  It sits on the config chain ahead of scm and forwards all foreign packets unchanged.
// PARAMETERS
//  LMID       8'd8           own module ID matched against cin_data[103:96]
//  ADDR_BASE  32'h80000000   register base; offsets below are added to it
// PORTS
//  clk              in   1    system clock
//  rst_n            in   1    asynchronous active-low reset
//  cin_data         in   134  config beat from previous module
//  cin_data_wr      in   1    config beat valid
//  cout_ready       out  1    ready to previous module; combinational copy of cin_ready
//  cout_data        out  134  config beat to next module (registered)
//  cout_data_wr     out  1    config beat valid to next module
//  cin_ready        in   1    ready from next module
//  sched_sent_start out  1    level: window open (wire to gac2scm_sent_start)
//  sched_sent_end   out  1    1-cycle pulse: window closed (wire to gac2scm_sent_end)
//  sched_busy       out  1    high in any state except IDLE/DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, FSM=IDLE, all registers/counters 0.
//  Config beat: [133:132]=01 header, 10 tail; [126:124] 010=write, 001=read; [95:64] addr; [31:0] data.
//  Registers (offset): 0 CTRL wo (bit0 start, bit1 abort, self-clearing); 1 WIN_LEN; 2 GAP_LEN;
//   3 WIN_CNT (0 = unlimited); 8 STATUS ro {27'b0, done_flag, 1'b0, state[2:0]}; 9 WIN_DONE ro; A CYC_CNT ro.
//  Header accepted only when cin_data_wr & cin_ready. Write to LMID: header and its tail consumed
//   (cout_data_wr=0 both cycles); register updates at the edge ending the header cycle.
//  Read to LMID at offset 8/9/A: cout_data = {in[133:128],4'b1011,in[123:112],in[103:96],
//   in[111:104],in[95:32],rdata}, 1-cycle latency; tail forwarded. Other offsets: beat forwarded as-is.
//  Any other beat: forwarded with 1-cycle latency. No valid beat: cout_data=0, cout_data_wr=0.
//  FSM IDLE/RUN/END/GAP/DONE; transitions on the edge after the condition:
//   IDLE: start=1 -> RUN; win_cnt_q<=0, cyc<=0. DONE: start=1 -> RUN (restart, counters cleared).
//   RUN: sched_sent_start=1; cyc counts 1..WIN_LEN; at cyc==max(WIN_LEN,1) -> END.
//   END: sched_sent_start=0, sched_sent_end=1 (exactly one cycle); WIN_DONE+=1;
//    -> GAP if GAP_LEN!=0, else -> RUN, or -> DONE when WIN_CNT!=0 and WIN_DONE+1==WIN_CNT.
//   GAP: count GAP_LEN cycles -> RUN, or DONE under the same WIN_CNT rule (evaluated at END exit).
//  WIN_LEN=0 treated as 1. CYC_CNT is 32-bit free counter of cycles in RUN since start; wraps 2^32-1 -> 0.
//  start while RUN/END/GAP: ignored. abort in RUN: -> END (single end pulse), then IDLE.
//  abort in GAP/END: -> IDLE after END completes. abort in IDLE/DONE: no effect.
//  start and abort in same write: abort wins. WIN_LEN/GAP_LEN writes mid-window take effect next window.
//  rst_n low mid-window: sched_sent_start drops async, no end pulse generated.
//  done_flag set on DONE entry, cleared on next start.
// TESTING
//  1 WIN_LEN=4,GAP_LEN=2,WIN_CNT=2,start -> start high 4 cyc, end pulse, 2 gap, repeat; DONE, WIN_DONE=2.
//  2 Read offset 9 to LMID after test1 -> response opcode 1011, MIDs swapped, [31:0]=2, 1-cycle latency.
//  3 Write to MID 8'd7 (other module) -> header+tail forwarded unchanged; no register changed.
//  4 WIN_LEN=0,GAP_LEN=0,WIN_CNT=1 -> start high 1 cycle, end pulse next cycle, then DONE.
//  5 WIN_CNT=0,WIN_LEN=10, abort at cycle 5 of RUN -> one end pulse, IDLE, busy=0, WIN_DONE=1.
//  6 rst_n=0 mid-RUN -> sched_sent_start=0 immediately, no end pulse, STATUS reads 0 after release.

Source files
------------

// File: rtl/gac_win_sched.sv
// Measurement-window scheduler on the 134-bit config chain: sequences N start/end windows for scm
// and forwards every foreign config beat one cycle later.
module gac_win_sched #(
  parameter logic [7:0]  LMID      = 8'd8,
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] cin_data,
  input  logic         cin_data_wr,
  output logic         cout_ready,
  output logic [133:0] cout_data,
  output logic         cout_data_wr,
  input  logic         cin_ready,
  output logic         sched_sent_start,
  output logic         sched_sent_end,
  output logic         sched_busy
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRun  = 3'd1,
    StEnd  = 3'd2,
    StGap  = 3'd3,
    StDone = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [133:0] cout_data_q, cout_data_d;
  logic         cout_wr_q, cout_wr_d;
  logic         drop_q, drop_d;

  logic [31:0] cfg_win_len_q, cfg_win_len_d;
  logic [31:0] cfg_gap_len_q, cfg_gap_len_d;
  logic [31:0] cfg_win_cnt_q, cfg_win_cnt_d;
  logic        start_q, start_d;
  logic        abort_q, abort_d;

  logic [31:0] win_len_act_q, win_len_act_d;
  logic [31:0] gap_len_act_q, gap_len_act_d;
  logic [31:0] win_cyc_q, win_cyc_d;
  logic [31:0] gap_cyc_q, gap_cyc_d;
  logic [31:0] win_done_q, win_done_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic        done_flag_q, done_flag_d;
  logic        abort_pend_q, abort_pend_d;
  logic        last_q, last_d;

  // Config beat decode
  logic        beat_acc;
  logic        is_hdr;
  logic        is_tail;
  logic        to_me;
  logic        is_wr;
  logic        is_rd;
  logic        rd_hit;
  logic [31:0] offset;
  logic [31:0] status;
  logic [31:0] rdata;

  assign beat_acc = cin_data_wr & cin_ready;
  assign is_hdr   = (cin_data[133:132] == 2'b01);
  assign is_tail  = (cin_data[133:132] == 2'b10);
  assign to_me    = (cin_data[103:96] == LMID);
  assign is_wr    = (cin_data[126:124] == 3'b010);
  assign is_rd    = (cin_data[126:124] == 3'b001);
  assign offset   = cin_data[95:64] - ADDR_BASE;
  assign rd_hit   = (offset == 32'd8) || (offset == 32'd9) || (offset == 32'd10);
  assign status   = {27'b0, done_flag_q, 1'b0, state_q};

  always_comb begin
    case (offset)
      32'd8:   rdata = status;
      32'd9:   rdata = win_done_q;
      32'd10:  rdata = cyc_cnt_q;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    cout_data_d   = '0;
    cout_wr_d     = 1'b0;
    drop_d        = drop_q;
    cfg_win_len_d = cfg_win_len_q;
    cfg_gap_len_d = cfg_gap_len_q;
    cfg_win_cnt_d = cfg_win_cnt_q;
    start_d       = 1'b0;
    abort_d       = 1'b0;
    if (beat_acc) begin
      if (drop_q) begin
        // Swallow the tail belonging to a consumed local write.
        if (is_tail) drop_d = 1'b0;
      end else if (is_hdr && to_me && is_wr) begin
        drop_d = 1'b1;
        case (offset)
          32'd0: begin
            start_d = cin_data[0];
            abort_d = cin_data[1];
          end
          32'd1:   cfg_win_len_d = cin_data[31:0];
          32'd2:   cfg_gap_len_d = cin_data[31:0];
          32'd3:   cfg_win_cnt_d = cin_data[31:0];
          default: ;
        endcase
      end else if (is_hdr && to_me && is_rd && rd_hit) begin
        cout_data_d = {cin_data[133:128], 4'b1011, cin_data[123:112], cin_data[103:96],
                       cin_data[111:104], cin_data[95:32], rdata};
        cout_wr_d   = 1'b1;
      end else begin
        cout_data_d = cin_data;
        cout_wr_d   = 1'b1;
      end
    end
  end

  // Window sequencer
  logic go;
  logic last_win;
  logic enter_run;

  assign go       = start_q & ~abort_q;
  assign last_win = (cfg_win_cnt_q != 32'd0) && ((win_done_q + 32'd1) == cfg_win_cnt_q);

  always_comb begin
    state_d       = state_q;
    win_len_act_d = win_len_act_q;
    gap_len_act_d = gap_len_act_q;
    win_cyc_d     = win_cyc_q;
    gap_cyc_d     = gap_cyc_q;
    win_done_d    = win_done_q;
    cyc_cnt_d     = cyc_cnt_q;
    done_flag_d   = done_flag_q;
    abort_pend_d  = abort_pend_q;
    last_d        = last_q;
    enter_run     = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (go) begin
          state_d      = StRun;
          enter_run    = 1'b1;
          win_done_d   = '0;
          cyc_cnt_d    = '0;
          done_flag_d  = 1'b0;
          abort_pend_d = 1'b0;
          last_d       = 1'b0;
        end
      end
      StRun: begin
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        win_cyc_d = win_cyc_q + 32'd1;
        if (abort_q) begin
          abort_pend_d = 1'b1;
          state_d      = StEnd;
        end else if (win_cyc_q == (win_len_act_q - 32'd1)) begin
          state_d = StEnd;
        end
      end
      StEnd: begin
        win_done_d   = win_done_q + 32'd1;
        last_d       = last_win;
        abort_pend_d = 1'b0;
        if (abort_q || abort_pend_q) begin
          state_d = StIdle;
        end else if (gap_len_act_q != 32'd0) begin
          state_d   = StGap;
          gap_cyc_d = '0;
        end else if (last_win) begin
          state_d     = StDone;
          done_flag_d = 1'b1;
        end else begin
          state_d   = StRun;
          enter_run = 1'b1;
        end
      end
      StGap: begin
        if (abort_q) begin
          state_d = StIdle;
        end else if (gap_cyc_q == (gap_len_act_q - 32'd1)) begin
          if (last_q) begin
            state_d     = StDone;
            done_flag_d = 1'b1;
          end else begin
            state_d   = StRun;
            enter_run = 1'b1;
          end
        end else begin
          gap_cyc_d = gap_cyc_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Lengths are sampled per window so mid-window writes apply to the next one.
    if (enter_run) begin
      win_cyc_d     = '0;
      win_len_act_d = (cfg_win_len_q == 32'd0) ? 32'd1 : cfg_win_len_q;
      gap_len_act_d = cfg_gap_len_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cout_data_q   <= '0;
      cout_wr_q     <= 1'b0;
      drop_q        <= 1'b0;
      cfg_win_len_q <= '0;
      cfg_gap_len_q <= '0;
      cfg_win_cnt_q <= '0;
      start_q       <= 1'b0;
      abort_q       <= 1'b0;
      win_len_act_q <= '0;
      gap_len_act_q <= '0;
      win_cyc_q     <= '0;
      gap_cyc_q     <= '0;
      win_done_q    <= '0;
      cyc_cnt_q     <= '0;
      done_flag_q   <= 1'b0;
      abort_pend_q  <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cout_data_q   <= cout_data_d;
      cout_wr_q     <= cout_wr_d;
      drop_q        <= drop_d;
      cfg_win_len_q <= cfg_win_len_d;
      cfg_gap_len_q <= cfg_gap_len_d;
      cfg_win_cnt_q <= cfg_win_cnt_d;
      start_q       <= start_d;
      abort_q       <= abort_d;
      win_len_act_q <= win_len_act_d;
      gap_len_act_q <= gap_len_act_d;
      win_cyc_q     <= win_cyc_d;
      gap_cyc_q     <= gap_cyc_d;
      win_done_q    <= win_done_d;
      cyc_cnt_q     <= cyc_cnt_d;
      done_flag_q   <= done_flag_d;
      abort_pend_q  <= abort_pend_d;
      last_q        <= last_d;
    end
  end

  assign cout_ready       = cin_ready;
  assign cout_data        = cout_data_q;
  assign cout_data_wr     = cout_wr_q;
  assign sched_sent_start = (state_q == StRun);
  assign sched_sent_end   = (state_q == StEnd);
  assign sched_busy       = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_gac_win_sched.sv
// Bench for gac_win_sched: phase-countdown reference model checked every cycle, plus directed
// literal expectations for each scheduling scenario.
module tb_gac_win_sched;

  logic         clk;
  logic         rst_n;
  logic [133:0] cin_data;
  logic         cin_data_wr;
  logic         cout_ready;
  logic [133:0] cout_data;
  logic         cout_data_wr;
  logic         cin_ready;
  logic         sched_sent_start;
  logic         sched_sent_end;
  logic         sched_busy;

  int n_chk = 0;
  int n_fail = 0;
  int n_start_cyc = 0;
  int n_end_pulse = 0;

  localparam logic [2:0] PH_IDLE = 3'd0, PH_RUN = 3'd1, PH_END = 3'd2, PH_GAP = 3'd3,
                         PH_DONE = 3'd4;
  localparam logic [133:0] TAIL = {2'b10, 100'h0, 32'hDEAD_BEEF};

  // Reference model state
  logic [2:0]   m_ph;
  logic [31:0]  m_left, m_wlen, m_glen, m_wcnt, m_done, m_cyc, m_gap_win;
  logic         m_flag, m_abort_after, m_last, m_start_p, m_abort_p, m_drop;
  logic [133:0] m_cout;
  logic         m_cout_wr;

  gac_win_sched #(
    .LMID      (8'd8),
    .ADDR_BASE (32'h8000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cin_data         (cin_data),
    .cin_data_wr      (cin_data_wr),
    .cout_ready       (cout_ready),
    .cout_data        (cout_data),
    .cout_data_wr     (cout_data_wr),
    .cin_ready        (cin_ready),
    .sched_sent_start (sched_sent_start),
    .sched_sent_end   (sched_sent_end),
    .sched_busy       (sched_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [133:0] mk_hdr(input logic [2:0] op, input logic [7:0] mid,
                                          input logic [31:0] off, input logic [31:0] data);
    return {2'b01, 4'b0000, 1'b0, op, 12'h000, 8'h05, mid, 32'h8000_0000 + off,
            32'h1234_5678, data};
  endfunction

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_left = '0; m_wlen = '0; m_glen = '0; m_wcnt = '0; m_done = '0;
    m_cyc = '0; m_gap_win = '0; m_flag = 0; m_abort_after = 0; m_last = 0; m_start_p = 0;
    m_abort_p = 0; m_drop = 0; m_cout = '0; m_cout_wr = 0;
  endtask

  task automatic model_step();
    logic [133:0] n_cout;
    logic         n_wr, n_start, n_abort, n_drop, hdr, me, go;
    logic [31:0]  n_wlen, n_glen, n_wcnt, off, rd;
    n_cout = '0; n_wr = 0; n_start = 0; n_abort = 0; n_drop = m_drop;
    n_wlen = m_wlen; n_glen = m_glen; n_wcnt = m_wcnt;
    if (cin_data_wr && cin_ready) begin
      off = cin_data[95:64] - 32'h8000_0000;
      hdr = (cin_data[133:132] == 2'b01);
      me  = (cin_data[103:96] == 8'd8);
      if (m_drop) begin
        if (cin_data[133:132] == 2'b10) n_drop = 0;
      end else if (hdr && me && cin_data[126:124] == 3'b010) begin
        n_drop = 1;
        if (off == 0) begin
          n_start = cin_data[0];
          n_abort = cin_data[1];
        end else if (off == 1) n_wlen = cin_data[31:0];
        else if (off == 2) n_glen = cin_data[31:0];
        else if (off == 3) n_wcnt = cin_data[31:0];
      end else if (hdr && me && cin_data[126:124] == 3'b001 && off >= 8 && off <= 10) begin
        rd = (off == 8) ? {27'b0, m_flag, 1'b0, m_ph} : (off == 9) ? m_done : m_cyc;
        n_cout = {cin_data[133:128], 4'b1011, cin_data[123:112], cin_data[103:96],
                  cin_data[111:104], cin_data[95:32], rd};
        n_wr = 1;
      end else begin
        n_cout = cin_data;
        n_wr = 1;
      end
    end
    // Scheduler: m_left counts down the cycles remaining in RUN or GAP.
    go = m_start_p && !m_abort_p;
    if (m_ph == PH_IDLE || m_ph == PH_DONE) begin
      if (go) begin
        m_ph = PH_RUN; m_left = (m_wlen == 0) ? 1 : m_wlen; m_gap_win = m_glen;
        m_done = 0; m_cyc = 0; m_flag = 0; m_abort_after = 0; m_last = 0;
      end
    end else if (m_ph == PH_RUN) begin
      m_cyc = m_cyc + 1;
      if (m_abort_p) begin
        m_abort_after = 1; m_ph = PH_END;
      end else if (m_left == 1) m_ph = PH_END;
      else m_left = m_left - 1;
    end else if (m_ph == PH_END) begin
      m_done = m_done + 1;
      m_last = (m_wcnt != 0) && (m_done == m_wcnt);
      if (m_abort_p || m_abort_after) begin
        m_ph = PH_IDLE; m_abort_after = 0;
      end else if (m_gap_win != 0) begin
        m_ph = PH_GAP; m_left = m_gap_win;
      end else if (m_last) begin
        m_ph = PH_DONE; m_flag = 1;
      end else begin
        m_ph = PH_RUN; m_left = (m_wlen == 0) ? 1 : m_wlen; m_gap_win = m_glen;
      end
    end else if (m_ph == PH_GAP) begin
      if (m_abort_p) m_ph = PH_IDLE;
      else if (m_left == 1) begin
        if (m_last) begin
          m_ph = PH_DONE; m_flag = 1;
        end else begin
          m_ph = PH_RUN; m_left = (m_wlen == 0) ? 1 : m_wlen; m_gap_win = m_glen;
        end
      end else m_left = m_left - 1;
    end
    m_cout = n_cout; m_cout_wr = n_wr; m_drop = n_drop; m_start_p = n_start;
    m_abort_p = n_abort; m_wlen = n_wlen; m_glen = n_glen; m_wcnt = n_wcnt;
  endtask

  task automatic send_pkt(input logic [2:0] op, input logic [7:0] mid, input logic [31:0] off,
                          input logic [31:0] data, output logic [133:0] rh, output logic rhw,
                          output logic [133:0] rt, output logic rtw);
    @(posedge clk); #2;
    cin_data = mk_hdr(op, mid, off, data); cin_data_wr = 1;
    @(posedge clk); #2;
    rh = cout_data; rhw = cout_data_wr;
    cin_data = TAIL;
    @(posedge clk); #2;
    rt = cout_data; rtw = cout_data_wr;
    cin_data = '0; cin_data_wr = 0;
  endtask

  task automatic wr_reg(input logic [31:0] off, input logic [31:0] data,
                        output logic [1:0] wrs);
    logic [133:0] rh, rt;
    logic rhw, rtw;
    send_pkt(3'b010, 8'd8, off, data, rh, rhw, rt, rtw);
    wrs = {rhw, rtw};
  endtask

  task automatic rd_reg(input logic [31:0] off, output logic [133:0] rh, output logic rhw);
    logic [133:0] rt;
    logic rtw;
    send_pkt(3'b001, 8'd8, off, 32'h0, rh, rhw, rt, rtw);
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 20 && !sched_sent_start; i++) begin
      @(posedge clk); #2;
    end
    check(name, sched_sent_start, 1'b1);
  endtask

  initial begin
    logic [133:0] rh, rt;
    logic         rhw, rtw;
    logic [1:0]   wrs;
    int           s0, e0;

    rst_n = 0; cin_data = '0; cin_data_wr = 0; cin_ready = 1;
    model_reset();
    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
      end
      forever begin
        @(negedge clk);
        check("cout_ready", cout_ready, cin_ready);
        check("cout_wr", cout_data_wr, m_cout_wr);
        check("cout_data", cout_data, m_cout);
        check("sent_start", sched_sent_start, m_ph == PH_RUN);
        check("sent_end", sched_sent_end, m_ph == PH_END);
        check("busy", sched_busy, m_ph == PH_RUN || m_ph == PH_END || m_ph == PH_GAP);
        if (sched_sent_start) n_start_cyc++;
        if (sched_sent_end) n_end_pulse++;
      end
    join_none

    @(negedge clk);
    check("reset_outputs", {cout_data_wr, sched_sent_start, sched_sent_end, sched_busy}, 4'b0);
    check("reset_cout_data", cout_data, 134'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // 1: two windows of 4 with gaps of 2
    wr_reg(1, 4, wrs);
    check("local_write_consumed", wrs, 2'b00);
    wr_reg(2, 2, wrs);
    wr_reg(3, 2, wrs);
    s0 = n_start_cyc; e0 = n_end_pulse;
    wr_reg(0, 1, wrs);
    repeat (25) @(posedge clk);
    #2;
    check("t1_start_cycles", n_start_cyc - s0, 8);
    check("t1_end_pulses", n_end_pulse - e0, 2);
    check("t1_idle_after_done", sched_busy, 1'b0);
    rd_reg(8, rh, rhw);
    check("t1_status", rh[31:0], 32'h14);
    rd_reg(10, rh, rhw);
    check("t1_cyc_cnt", rh[31:0], 32'd8);

    // 2: WIN_DONE readback response format
    rd_reg(9, rh, rhw);
    check("t2_resp_wr", rhw, 1'b1);
    check("t2_resp_beat", rh, {6'b010000, 4'b1011, 12'h000, 8'h08, 8'h05, 32'h8000_0009,
                               32'h1234_5678, 32'd2});

    // 3: foreign write (CTRL start to MID 7) passes through untouched
    send_pkt(3'b010, 8'd7, 0, 1, rh, rhw, rt, rtw);
    check("t3_fwd_hdr", rh, mk_hdr(3'b010, 8'd7, 0, 1));
    check("t3_fwd_tail", rt, TAIL);
    check("t3_fwd_wr", {rhw, rtw}, 2'b11);
    repeat (4) @(posedge clk);
    #2;
    check("t3_no_start", sched_busy, 1'b0);
    cin_ready = 0; cin_data = mk_hdr(3'b001, 8'd7, 4, 0); cin_data_wr = 1;
    @(posedge clk); #2;
    cin_ready = 1; cin_data = '0; cin_data_wr = 0;
    check("t3_not_ready_dropped", cout_data_wr, 1'b0);

    // 4: zero lengths, single window
    wr_reg(1, 0, wrs);
    wr_reg(2, 0, wrs);
    wr_reg(3, 1, wrs);
    s0 = n_start_cyc; e0 = n_end_pulse;
    wr_reg(0, 1, wrs);
    repeat (10) @(posedge clk);
    #2;
    check("t4_start_cycles", n_start_cyc - s0, 1);
    check("t4_end_pulses", n_end_pulse - e0, 1);
    rd_reg(8, rh, rhw);
    check("t4_status", rh[31:0], 32'h14);
    rd_reg(9, rh, rhw);
    check("t4_win_done", rh[31:0], 32'd1);

    // 5: unlimited windows, abort mid-RUN
    wr_reg(3, 0, wrs);
    wr_reg(1, 10, wrs);
    e0 = n_end_pulse;
    wr_reg(0, 1, wrs);
    wait_start("t5_run_entered");
    repeat (2) @(posedge clk);
    wr_reg(0, 2, wrs);
    repeat (8) @(posedge clk);
    #2;
    check("t5_end_pulses", n_end_pulse - e0, 1);
    check("t5_busy", sched_busy, 1'b0);
    rd_reg(8, rh, rhw);
    check("t5_status", rh[31:0], 32'h00);
    rd_reg(9, rh, rhw);
    check("t5_win_done", rh[31:0], 32'd1);
    wr_reg(0, 3, wrs);
    repeat (4) @(posedge clk);
    #2;
    check("t5_abort_beats_start", sched_busy, 1'b0);

    // 6: reset mid-RUN
    e0 = n_end_pulse;
    wr_reg(0, 1, wrs);
    wait_start("t6_run_entered");
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("t6_start_async_drop", sched_sent_start, 1'b0);
    check("t6_busy_async_drop", sched_busy, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    repeat (3) @(posedge clk);
    rd_reg(8, rh, rhw);
    check("t6_status", rh[31:0], 32'h00);
    rd_reg(9, rh, rhw);
    check("t6_win_done", rh[31:0], 32'd0);
    check("t6_no_end_pulse", n_end_pulse - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
